first_edge_resolver: RTL and testbench



---
 rtl/first_edge_resolver_pkg.sv | 28 ++
 rtl/first_edge_resolver_rise_det.sv | 33 +++
 rtl/first_edge_resolver.sv | 148 ++++++++++++++
 tb/tb_first_edge_resolver.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/first_edge_resolver_pkg.sv
// -----------------------------------------------------------------------------
// first_edge_resolver_pkg
//   Shared types and helpers for the first_edge_resolver arbitration stage.
//   - state_e  : window FSM state (IDLE / ARMED)
//   - winner_e : which candidate, if any, decided in the current cycle
//   - sat_inc  : saturating increment for the debug outcome counters
// -----------------------------------------------------------------------------
package first_edge_resolver_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    WIN_NONE = 2'd0,
    WIN_B    = 2'd1,
    WIN_C    = 2'd2
  } winner_e;

  // Counters up to 32 bits wide share this helper; callers widen on the way in
  // and truncate on the way out, and pass their own all-ones ceiling.
  function automatic logic [31:0] sat_inc(input logic [31:0] cnt,
                                          input logic [31:0] max_val);
    return (cnt >= max_val) ? cnt : cnt + 32'd1;
  endfunction

endpackage

// File: rtl/first_edge_resolver_rise_det.sv
// -----------------------------------------------------------------------------
// rise_det
//   Single-bit rising-edge detector: rise = in & ~in_q.
//   The history flop resets to 0, so a level that is already high when reset
//   releases is reported as a rise on the first clock.
// Ports
//   clk  in  sampling clock
//   rst  in  asynchronous active-high reset
//   in   in  level input, synchronous to clk
//   rise out combinational rise indication for the current cycle
// -----------------------------------------------------------------------------
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic in_q;
  logic in_d;

  always_comb in_d = in;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, independent of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) in_q <= 1'b0;
    else     in_q <= in_d;
  end

  assign rise = in & ~in_q;

endmodule

// File: rtl/first_edge_resolver.sv
// -----------------------------------------------------------------------------
// first_edge_resolver
//   A rising edge of `a` opens a decision window; the first rising edge of `b`
//   or `c` inside it sets `d` (b -> 1, c -> 0), which then holds until the next
//   decision. Windows that see no candidate within TIMEOUT_CYC cycles are
//   abandoned with a `timeout` pulse. Saturating counters tally outcomes.
// Parameters
//   TIMEOUT_CYC  cycles a window may stay open (>= 1)
//   TIE_B_WINS   1: simultaneous b/c rise resolves to b, 0: to c
//   CNT_W        width of each saturating counter (1..32)
// Ports
//   clk, rst     clock, asynchronous active-high reset
//   a, b, c      level inputs, only rising edges matter
//   d            decision, held between decisions
//   d_valid      one-cycle pulse when d takes a new decision
//   busy         window open
//   timeout      one-cycle pulse when a window expires
//   b_wins, c_wins, to_cnt  saturating outcome counters
// -----------------------------------------------------------------------------
module first_edge_resolver
  import first_edge_resolver_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter bit          TIE_B_WINS  = 1'b1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a,
  input  logic             b,
  input  logic             c,
  output logic             d,
  output logic             d_valid,
  output logic             busy,
  output logic             timeout,
  output logic [CNT_W-1:0] b_wins,
  output logic [CNT_W-1:0] c_wins,
  output logic [CNT_W-1:0] to_cnt
);

  localparam int unsigned      TIMER_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYC - 1);
  localparam logic [31:0]      CNT_MAX    = 32'((64'd1 << CNT_W) - 64'd1);

  logic rise_a, rise_b, rise_c;

  rise_det u_rise_a (.clk(clk), .rst(rst), .in(a), .rise(rise_a));
  rise_det u_rise_b (.clk(clk), .rst(rst), .in(b), .rise(rise_b));
  rise_det u_rise_c (.clk(clk), .rst(rst), .in(c), .rise(rise_c));

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               d_q, d_d;
  logic               d_valid_q, d_valid_d;
  logic               timeout_q, timeout_d;
  logic [CNT_W-1:0]   b_wins_q, b_wins_d;
  logic [CNT_W-1:0]   c_wins_q, c_wins_d;
  logic [CNT_W-1:0]   to_cnt_q, to_cnt_d;
  winner_e            winner;

  // Candidate resolution only matters while a window is open; edges seen in
  // IDLE (including alongside the opening rise_a) are deliberately dropped.
  always_comb begin
    winner = WIN_NONE;
    if (state_q == ARMED) begin
      if (rise_b && rise_c) winner = TIE_B_WINS ? WIN_B : WIN_C;
      else if (rise_b)      winner = WIN_B;
      else if (rise_c)      winner = WIN_C;
    end
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    d_d       = d_q;
    d_valid_d = 1'b0;
    timeout_d = 1'b0;
    b_wins_d  = b_wins_q;
    c_wins_d  = c_wins_q;
    to_cnt_d  = to_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (rise_a) begin
          state_d = ARMED;
          timer_d = '0;
        end
      end
      ARMED: begin
        // A decision outranks a simultaneous rise_a, which is then consumed
        // without opening a new window.
        if (winner == WIN_B) begin
          d_d       = 1'b1;
          d_valid_d = 1'b1;
          b_wins_d  = CNT_W'(sat_inc(32'(b_wins_q), CNT_MAX));
          state_d   = IDLE;
        end else if (winner == WIN_C) begin
          d_d       = 1'b0;
          d_valid_d = 1'b1;
          c_wins_d  = CNT_W'(sat_inc(32'(c_wins_q), CNT_MAX));
          state_d   = IDLE;
        end else if (rise_a) begin
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          timeout_d = 1'b1;
          to_cnt_d  = CNT_W'(sat_inc(32'(to_cnt_q), CNT_MAX));
          state_d   = IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      d_q       <= 1'b0;
      d_valid_q <= 1'b0;
      timeout_q <= 1'b0;
      b_wins_q  <= '0;
      c_wins_q  <= '0;
      to_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      d_q       <= d_d;
      d_valid_q <= d_valid_d;
      timeout_q <= timeout_d;
      b_wins_q  <= b_wins_d;
      c_wins_q  <= c_wins_d;
      to_cnt_q  <= to_cnt_d;
    end
  end

  assign d       = d_q;
  assign d_valid = d_valid_q;
  assign busy    = (state_q == ARMED);
  assign timeout = timeout_q;
  assign b_wins  = b_wins_q;
  assign c_wins  = c_wins_q;
  assign to_cnt  = to_cnt_q;

endmodule

// File: tb/tb_first_edge_resolver.sv
// -----------------------------------------------------------------------------
// tb_first_edge_resolver
//   Directed vectors against a default instance and an instance with the tie
//   rule inverted and 2-bit counters (saturation), then a random run checked
//   cycle by cycle against a behavioural model of the window protocol.
// -----------------------------------------------------------------------------
module tb_first_edge_resolver;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst;
  logic a, b, c;

  logic       d, d_valid, busy, timeout;
  logic [7:0] b_wins, c_wins, to_cnt;
  logic       d2, d_valid2, busy2, timeout2;
  logic [1:0] b_wins2, c_wins2, to_cnt2;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  first_edge_resolver #(.TIMEOUT_CYC(TIMEOUT), .TIE_B_WINS(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .d(d), .d_valid(d_valid), .busy(busy), .timeout(timeout),
    .b_wins(b_wins), .c_wins(c_wins), .to_cnt(to_cnt)
  );

  first_edge_resolver #(.TIMEOUT_CYC(TIMEOUT), .TIE_B_WINS(1'b0), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
    .d(d2), .d_valid(d_valid2), .busy(busy2), .timeout(timeout2),
    .b_wins(b_wins2), .c_wins(c_wins2), .to_cnt(to_cnt2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance n clocks; outputs are sampled 1 time unit after the edge.
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_in(input logic va, input logic vb, input logic vc);
    a = va;
    b = vb;
    c = vc;
  endtask

  // Behavioural model state for the random run (default instance).
  bit m_armed, m_d, m_dv, m_to, ma, mb, mc;
  int m_timer, m_b, m_c, m_t;

  task automatic model_clock();
    bit ra, rb, rc;
    ra = a & ~ma; rb = b & ~mb; rc = c & ~mc;
    ma = a; mb = b; mc = c;
    m_dv = 0;
    m_to = 0;
    if (!m_armed) begin
      if (ra) begin m_armed = 1; m_timer = 0; end
    end else if (rb || rc) begin
      m_d = rb;            // tie goes to b in the default instance
      m_dv = 1;
      if (rb) m_b = (m_b == 255) ? 255 : m_b + 1;
      else    m_c = (m_c == 255) ? 255 : m_c + 1;
      m_armed = 0;
    end else if (ra) begin
      m_timer = 0;
    end else if (m_timer == TIMEOUT - 1) begin
      m_to = 1;
      m_t = (m_t == 255) ? 255 : m_t + 1;
      m_armed = 0;
    end else begin
      m_timer++;
    end
  endtask

  initial begin
    rst = 1'b1;
    set_in(0, 0, 0);
    step(2);

    // Reset state
    check("rst_d", 32'(d), 0);
    check("rst_dvalid", 32'(d_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_cnts", 32'({b_wins, c_wins, to_cnt}), 0);
    rst = 1'b0;
    step();

    // 1: a rises, b rises two cycles later -> d=1
    set_in(1, 0, 0); step();
    check("t1_busy_open", 32'(busy), 1);
    step();
    check("t1_busy_hold", 32'(busy), 1);
    check("t1_no_dv_yet", 32'(d_valid), 0);
    set_in(1, 1, 0); step();
    check("t1_d", 32'(d), 1);
    check("t1_dvalid", 32'(d_valid), 1);
    check("t1_busy_closed", 32'(busy), 0);
    check("t1_b_wins", 32'(b_wins), 1);
    step();
    check("t1_dv_pulse", 32'(d_valid), 0);
    check("t1_d_held", 32'(d), 1);
    set_in(0, 0, 0); step();

    // 2: a rises, c rises three cycles later -> d=0
    set_in(1, 0, 0); step(3);
    set_in(1, 0, 1); step();
    check("t2_d", 32'(d), 0);
    check("t2_dvalid", 32'(d_valid), 1);
    check("t2_c_wins", 32'(c_wins), 1);
    set_in(0, 0, 0); step();

    // 3: tie -> b for default, c for the inverted instance
    set_in(1, 0, 0); step();
    set_in(1, 1, 1); step();
    check("t3_tie_b", 32'(d), 1);
    check("t3_tie_c", 32'(d2), 0);
    check("t3_dv2", 32'(d_valid2), 1);
    check("t3_b_wins", 32'(b_wins), 2);
    check("t3_c_wins2", 32'(c_wins2), 2);
    set_in(0, 0, 0); step();

    // 4: timeout 16 cycles after arming, d unchanged
    set_in(1, 0, 0); step();
    set_in(0, 0, 0); step(15);
    check("t4_not_yet", 32'(timeout), 0);
    check("t4_busy_last", 32'(busy), 1);
    step();
    check("t4_timeout", 32'(timeout), 1);
    check("t4_busy_off", 32'(busy), 0);
    check("t4_to_cnt", 32'(to_cnt), 1);
    check("t4_d_kept", 32'(d), 1);
    check("t4_d2_kept", 32'(d2), 0);
    check("t4_no_dv", 32'(d_valid), 0);
    step();
    check("t4_to_pulse", 32'(timeout), 0);

    // 5: re-arm after 10 cycles, b 12 cycles later -> no timeout
    set_in(1, 0, 0); step();
    set_in(0, 0, 0); step(9);
    set_in(1, 0, 0); step();
    set_in(0, 0, 0); step(11);
    check("t5_busy", 32'(busy), 1);
    set_in(0, 1, 0); step();
    check("t5_d", 32'(d), 1);
    check("t5_dvalid", 32'(d_valid), 1);
    check("t5_to_cnt", 32'(to_cnt), 1);
    set_in(0, 0, 0); step();

    // Decision beats simultaneous rise_a; no new window opens
    set_in(1, 0, 0); step();
    set_in(0, 0, 0); step();
    set_in(1, 0, 1); step();
    check("beat_d", 32'(d), 0);
    check("beat_dvalid", 32'(d_valid), 1);
    check("beat_busy", 32'(busy), 0);
    step();
    check("beat_no_rearm", 32'(busy), 0);
    set_in(0, 0, 0); step();

    // Candidate rises in IDLE and alongside rise_a are ignored
    set_in(0, 1, 0); step();
    check("idle_b_dv", 32'(d_valid), 0);
    check("idle_b_busy", 32'(busy), 0);
    set_in(1, 1, 1); step();
    check("idle_ac_busy", 32'(busy), 1);
    check("idle_ac_dv", 32'(d_valid), 0);
    set_in(0, 0, 0); step();
    set_in(0, 1, 0); step();
    check("idle_then_b", 32'(d), 1);
    check("idle_b_wins", 32'(b_wins), 4);
    set_in(0, 0, 0); step();

    // Saturation on the 2-bit instance: one c and two b decisions
    set_in(1, 0, 0); step();
    set_in(1, 0, 1); step();
    set_in(0, 0, 0); step();
    for (int i = 0; i < 2; i++) begin
      set_in(1, 0, 0); step();
      set_in(1, 1, 0); step();
      set_in(0, 0, 0); step();
    end
    check("sat_b_wins8", 32'(b_wins), 6);
    check("sat_c_wins8", 32'(c_wins), 3);
    check("sat_b_wins2", 32'(b_wins2), 3);
    check("sat_c_wins2", 32'(c_wins2), 3);
    check("sat_to_cnt2", 32'(to_cnt2), 1);

    // 6: b in IDLE, open a window, then asynchronous reset mid-window
    set_in(0, 1, 0); step();
    check("t6_idle_b", 32'(d_valid), 0);
    set_in(1, 1, 0); step();
    check("t6_armed", 32'(busy), 1);
    #2 rst = 1'b1;
    #1;
    check("t6_async_d", 32'(d), 0);
    check("t6_async_busy", 32'(busy), 0);
    check("t6_async_cnts", 32'({b_wins, c_wins, to_cnt}), 0);
    check("t6_async_cnts2", 32'({b_wins2, c_wins2, to_cnt2}), 0);
    check("t6_async_dv", 32'(d_valid), 0);
    step();
    rst = 1'b0;
    step();
    // a and b held high through reset count as rises on the first clock
    check("rel_rise_busy", 32'(busy), 1);
    check("rel_rise_dv", 32'(d_valid), 0);

    // Random protocol run against the model
    set_in(0, 0, 0);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    m_armed = 0; m_d = 0; m_dv = 0; m_to = 0; ma = 0; mb = 0; mc = 0;
    m_timer = 0; m_b = 0; m_c = 0; m_t = 0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if ($urandom_range(0, 5) == 0) a = ~a;
      if ($urandom_range(0, 9) == 0) b = ~b;
      if ($urandom_range(0, 9) == 0) c = ~c;
      model_clock();
      step();
      check("rnd_d", 32'(d), 32'(m_d));
      check("rnd_dvalid", 32'(d_valid), 32'(m_dv));
      check("rnd_busy", 32'(busy), 32'(m_armed));
      check("rnd_timeout", 32'(timeout), 32'(m_to));
      check("rnd_b_wins", 32'(b_wins), 32'(m_b));
      check("rnd_c_wins", 32'(c_wins), 32'(m_c));
      check("rnd_to_cnt", 32'(to_cnt), 32'(m_t));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
